// File: rtl/mem_fill_pkg.sv
// Shared types for the memory fill engine: fill mode and FSM state encodings.
package mem_fill_pkg;

  localparam int unsigned MODE_W = 2;

  // Fill pattern selector; code 3 is not listed and falls back to identity.
  typedef enum logic [1:0] {
    MODE_IDENTITY = 2'd0,
    MODE_CONST    = 2'd1,
    MODE_STEP     = 2'd2
  } fill_mode_e;

  // Engine states; VRD/VWAIT/VCMP are only reachable in verify builds.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_VRD   = 3'd2,
    ST_VWAIT = 3'd3,
    ST_VCMP  = 3'd4,
    ST_DONE  = 3'd5
  } fill_state_e;

endpackage

// File: rtl/mem_fill_datagen.sv
// Pattern generator: value written to (and expected back from) index i.
module mem_fill_datagen
  import mem_fill_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic [MODE_W-1:0] i_mode,
  input  logic [DATA_W-1:0] i_fill_value,
  input  logic [DATA_W-1:0] i_step,
  input  logic [ADDR_W:0]   i_idx,
  output logic [DATA_W-1:0] o_gen_c
);

  logic [DATA_W-1:0] w_idx_d;

  assign w_idx_d = DATA_W'(i_idx);

  // Select the pattern; all arithmetic wraps modulo 2**DATA_W.
  always_comb begin
    o_gen_c = w_idx_d;
    case (i_mode)
      MODE_CONST: o_gen_c = i_fill_value;
      MODE_STEP:  o_gen_c = i_fill_value + w_idx_d * i_step;
      default:    o_gen_c = w_idx_d;
    endcase
  end

endmodule

// File: rtl/mem_fill_engine.sv
// Memory fill engine: writes DEPTH locations with a generated pattern,
// optionally reading them back and flagging the first mismatch.
// Optional feature macro: MEM_FILL_VERIFY_EN (read-back verify).
module mem_fill_engine
  import mem_fill_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [MODE_W-1:0] mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [DATA_W-1:0] step,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  // One extra index bit so a full 2**ADDR_W fill terminates cleanly.
  localparam int unsigned IDX_W    = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  fill_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [MODE_W-1:0] r_mode, w_mode_nxt;
  logic [DATA_W-1:0] r_fill, w_fill_nxt;
  logic [DATA_W-1:0] r_step, w_step_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_wren, w_wren_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [DATA_W-1:0] w_gen;
  logic              w_last;

`ifdef MEM_FILL_VERIFY_EN
  localparam int unsigned WAIT_CYC  = (RD_LAT > 1) ? RD_LAT - 1 : 1;
  localparam logic [1:0]  WAIT_LAST = 2'(WAIT_CYC - 1);

  logic [1:0]        r_wait, w_wait_nxt;
  logic [DATA_W-1:0] r_exp;
  logic              r_error, w_error_nxt;
  logic [ADDR_W-1:0] r_err_addr, w_err_addr_nxt;
  logic              w_mismatch;

  assign w_mismatch = (mem_rdata != r_exp);
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^{mem_rdata, 2'(RD_LAT)};
`endif

  assign w_last = (r_idx == LAST_IDX);

  // Single pattern generator, fed with next-cycle config and index so the
  // registered write data and the captured compare value line up with state.
  mem_fill_datagen #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_datagen (
    .i_mode      (w_mode_nxt),
    .i_fill_value(w_fill_nxt),
    .i_step      (w_step_nxt),
    .i_idx       (w_idx_nxt),
    .o_gen_c     (w_gen)
  );

  // Next-state, index and config logic; abort wins in every busy state.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_mode_nxt  = r_mode;
    w_fill_nxt  = r_fill;
    w_step_nxt  = r_step;
`ifdef MEM_FILL_VERIFY_EN
    w_wait_nxt     = r_wait;
    w_error_nxt    = r_error;
    w_err_addr_nxt = r_err_addr;
`endif
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_WRITE;
          w_idx_nxt   = '0;
          w_mode_nxt  = mode;
          w_fill_nxt  = fill_value;
          w_step_nxt  = step;
`ifdef MEM_FILL_VERIFY_EN
          w_error_nxt    = 1'b0;
          w_err_addr_nxt = '0;
`endif
        end
      end
      ST_WRITE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
`ifdef MEM_FILL_VERIFY_EN
          w_state_nxt = ST_VRD;
          w_idx_nxt   = '0;
`else
          w_state_nxt = ST_DONE;
`endif
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
`ifdef MEM_FILL_VERIFY_EN
      ST_VRD: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (RD_LAT <= 1) begin
          w_state_nxt = ST_VCMP;
        end else begin
          w_state_nxt = ST_VWAIT;
          w_wait_nxt  = '0;
        end
      end
      ST_VWAIT: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_wait == WAIT_LAST) begin
          w_state_nxt = ST_VCMP;
        end else begin
          w_wait_nxt = r_wait + 2'd1;
        end
      end
      ST_VCMP: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          if (w_mismatch && !r_error) begin
            w_error_nxt    = 1'b1;
            w_err_addr_nxt = r_idx[ADDR_W-1:0];
          end
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_VRD;
            w_idx_nxt   = r_idx + IDX_W'(1);
          end
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  assign w_wren_nxt  = (w_state_nxt == ST_WRITE);
  assign w_done_nxt  = (w_state_nxt == ST_DONE);
  assign w_busy_nxt  = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
  assign w_addr_nxt  = w_busy_nxt ? w_idx_nxt[ADDR_W-1:0] : r_addr;
  assign w_wdata_nxt = w_wren_nxt ? w_gen : r_wdata;

  // State, config and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_mode  <= '0;
      r_fill  <= '0;
      r_step  <= '0;
      r_addr  <= '0;
      r_wren  <= 1'b0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef MEM_FILL_VERIFY_EN
      r_wait     <= '0;
      r_exp      <= '0;
      r_error    <= 1'b0;
      r_err_addr <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_mode  <= w_mode_nxt;
      r_fill  <= w_fill_nxt;
      r_step  <= w_step_nxt;
      r_addr  <= w_addr_nxt;
      r_wren  <= w_wren_nxt;
      r_wdata <= w_wdata_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef MEM_FILL_VERIFY_EN
      r_wait     <= w_wait_nxt;
      r_error    <= w_error_nxt;
      r_err_addr <= w_err_addr_nxt;
      if (w_state_nxt == ST_VRD) begin
        r_exp <= w_gen;
      end
`endif
    end
  end

  assign mem_address = r_addr;
  assign mem_wren    = r_wren;
  assign mem_wdata   = r_wdata;
  assign busy        = r_busy;
  assign done        = r_done;
`ifdef MEM_FILL_VERIFY_EN
  assign error       = r_error;
  assign err_addr    = r_err_addr;
`else
  assign error       = 1'b0;
  assign err_addr    = '0;
`endif

endmodule

// File: tb/tb_mem_fill_engine.sv
// Self-checking bench for mem_fill_engine (default and MEM_FILL_VERIFY_EN builds).
module tb_mem_fill_engine;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned RDL   = 2;
`ifdef MEM_FILL_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, abort;
  logic [1:0]    mode;
  logic [DW-1:0] fill_value, step;
  logic [AW-1:0] mem_address, err_addr;
  logic          mem_wren, busy, done, error;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // Small instance for the DEPTH = 2**ADDR_W = 16 case.
  logic          s_start, s_abort;
  logic [1:0]    s_mode;
  logic [7:0]    s_fv, s_step, s_wdata, s_rdata;
  logic [3:0]    s_addr, s_err_addr;
  logic          s_wren, s_busy, s_done, s_error;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [7:0] mem_model [0:255];
  logic [7:0] rd_pipe   [0:2];
  bit         corrupt_on = 1'b0;

  always #5 clk = ~clk;

  mem_fill_engine #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(RDL)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .mode(mode),
    .fill_value(fill_value), .step(step), .mem_address(mem_address),
    .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr)
  );

  mem_fill_engine #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .RD_LAT(1)) u_small (
    .clk(clk), .reset_n(reset_n), .start(s_start), .abort(s_abort), .mode(s_mode),
    .fill_value(s_fv), .step(s_step), .mem_address(s_addr),
    .mem_wren(s_wren), .mem_wdata(s_wdata), .mem_rdata(s_rdata),
    .busy(s_busy), .done(s_done), .error(s_error), .err_addr(s_err_addr)
  );

  assign s_rdata = 8'hA5;

  // Memory with RD_LAT-deep read pipeline; addresses 7 and 9 can read back corrupted.
  always @(posedge clk) begin
    if (mem_wren) mem_model[mem_address] <= mem_wdata;
    rd_pipe[0] <= mem_model[mem_address] ^
                  ((corrupt_on && (mem_address == 8'd7 || mem_address == 8'd9)) ? 8'hFF : 8'h00);
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign mem_rdata = rd_pipe[RDL-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference pattern straight from the fill rules.
  function automatic logic [7:0] gen_ref(input logic [1:0] m, input logic [7:0] fv,
                                         input logic [7:0] st, input int k);
    int v;
    case (m)
      2'd1:    v = int'(fv);
      2'd2:    v = int'(fv) + k * int'(st);
      default: v = k;
    endcase
    return 8'(v % 256);
  endfunction

  function automatic logic [31:0] pack_wr(input logic w, input logic b, input logic d,
                                          input logic [7:0] a, input logic [7:0] dt);
    return 32'({w, b, d, a, dt});
  endfunction

  // One fill; optional abort, reset or ignored start at a given write index.
  task automatic run_fill(input logic [1:0] m, input logic [7:0] fv, input logic [7:0] st,
                          input int abort_at, input int rst_at, input int busy_start_at,
                          input bit corrupt);
    corrupt_on = corrupt;
    @(negedge clk);
    start = 1'b1; mode = m; fill_value = fv; step = st;
    @(negedge clk);
    start = 1'b0; mode = 2'($urandom); fill_value = 8'($urandom); step = 8'($urandom);
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (k > 0) @(negedge clk);
      start = 1'b0;
      check("write", pack_wr(mem_wren, busy, done, mem_address, mem_wdata),
            pack_wr(1'b1, 1'b1, 1'b0, 8'(k), gen_ref(m, fv, st, k)));
      if (k == busy_start_at) start = 1'b1;
      if (k == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", 32'({mem_wren, busy, done}), 32'd0);
        return;
      end
      if (k == rst_at) begin
        reset_n = 1'b0;
        #1;
        check("async_reset", 32'({mem_wren, busy, done, mem_address, mem_wdata, error, err_addr}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
    end
`ifdef MEM_FILL_VERIFY_EN
    begin : g_vfy
      int n = 0;
      int wren_bad = 0;
      while (!done && n < int'(DEPTH * (RDL + 1)) + 20) begin
        @(negedge clk);
        n++;
        if (mem_wren) wren_bad++;
      end
      check("verify_len", 32'(n), 32'(DEPTH * (RDL + 1) + 1));
      check("verify_wren", 32'(wren_bad), 32'd0);
    end
`else
    @(negedge clk);
`endif
    check("done", 32'({mem_wren, busy, done}), 32'(3'b001));
    check("error", 32'(error), 32'(VFY && corrupt));
    check("err_addr", 32'(err_addr), (VFY && corrupt) ? 32'd7 : 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("done_hold", 32'({mem_wren, busy, done}), 32'(3'b001));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; mode = '0; fill_value = '0; step = '0;
    s_start = 1'b0; s_abort = 1'b0; s_mode = '0; s_fv = '0; s_step = '0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({mem_wren, busy, done, mem_address, mem_wdata, error, err_addr}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'({mem_wren, busy, done}), 32'd0);

    // Identity fill with an ignored start mid-fill.
    run_fill(2'd0, 8'h00, 8'h00, -1, -1, 50, 1'b0);
    // Step fill and spot values with wrap.
    run_fill(2'd2, 8'h10, 8'h03, -1, -1, -1, 1'b0);
    check("step_a0",   32'(mem_model[0]),   32'h10);
    check("step_a1",   32'(mem_model[1]),   32'h13);
    check("step_a100", 32'(mem_model[100]), 32'h3C);
    check("step_a255", 32'(mem_model[255]), 32'h0D);
    // Abort at address 40, then restart from address 0.
    run_fill(2'd0, 8'h00, 8'h00, 40, -1, -1, 1'b0);
    run_fill(2'd1, 8'hA5, 8'h00, -1, -1, 10, 1'b0);
    // Reset at address 100, then a fresh fill.
    run_fill(2'd2, 8'($urandom), 8'($urandom), -1, 100, -1, 1'b0);
    run_fill(2'd3, 8'($urandom), 8'($urandom), -1, -1, -1, 1'b0);
    // Corrupted read-back at 7 and 9, then a clean run clears the flag.
    run_fill(2'd2, 8'($urandom), 8'($urandom), -1, -1, -1, 1'b1);
    run_fill(2'd1, 8'($urandom), 8'($urandom), -1, -1, -1, 1'b0);
    // Random fills.
    for (int r = 0; r < 3; r++) begin
      run_fill(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), -1, -1,
               int'($urandom_range(0, DEPTH - 2)), 1'b0);
    end

    // Full-range fill on the 16-deep instance: no address wrap.
    @(negedge clk);
    s_start = 1'b1; s_mode = 2'd1; s_fv = 8'hA5; s_step = 8'($urandom);
    @(negedge clk);
    s_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      check("small_write", 32'({s_wren, s_addr, s_wdata}), 32'({1'b1, 4'(k), 8'hA5}));
    end
    begin : g_small_wait
      int n = 0;
      @(negedge clk);
      while (!s_done && n < 60) begin
        @(negedge clk);
        n++;
      end
    end
    check("small_done", 32'({s_wren, s_busy, s_done, s_error}), 32'(4'b0010));
    check("small_addr", 32'(s_addr), 32'd15);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
